four_way_cache_ctrl: RTL and testbench
======================================

FOUR_WAY_CACHE_CTRL -- requirements
Module: four_way_cache_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 32, word width
  ADDR_WIDTH, 32, word address width
  NUM_SETS, 8, sets per way (power of 2); IDX_W = log2(NUM_SETS), TAG_W = ADDR_WIDTH - IDX_W
  NUM_WAYS, 4, ways (fixed at 4; the PLRU tree is 3 bits per set)
REQ-002 Ports SHALL be, one per line:
  clk_i  in  1  clock; one clock domain, all logic on the rising edge
  rst_i  in  1  reset, synchronous, active-high
  req_valid_i  in  1  CPU request valid
  req_ready_o  out  1  CPU request accepted when high with req_valid_i
  req_we_i  in  1  1 = write, 0 = read
  req_addr_i  in  ADDR_WIDTH  word address; index = [IDX_W-1:0], tag = upper bits
  req_data_i  in  DATA_WIDTH  write data
  resp_valid_o  out  1  one-cycle response pulse
  resp_data_o  out  DATA_WIDTH  read data; 0 for writes
  resp_hit_o  out  1  request hit in the cache
  way_index_o  out  IDX_W  set index driven to all way data arrays
  way_rdata_i  in  NUM_WAYS*DATA_WIDTH  combinational read data, way w at [w*DATA_WIDTH +: DATA_WIDTH]
  way_we_o  out  NUM_WAYS  one-hot way write enable
  way_wdata_o  out  DATA_WIDTH  way write data
  mem_req_valid_o  out  1  memory request valid
  mem_req_ready_i  in  1  memory accepts the request
  mem_we_o  out  1  memory write
  mem_addr_o  out  ADDR_WIDTH  memory address
  mem_wdata_o  out  DATA_WIDTH  memory write data
  mem_resp_valid_i  in  1  read data valid / write acknowledge
  mem_resp_data_i  in  DATA_WIDTH  memory read data
  hit_cnt_o  out  16  saturating hit counter
  miss_cnt_o  out  16  saturating miss counter

Function
REQ-003 The controller SHALL own the per-set tag array, the valid bits and the 3-bit PLRU state; the data arrays SHALL stay external.
REQ-004 The FSM SHALL have states IDLE, LOOKUP, MEM_REQ, MEM_WAIT, REFILL and RESP; req_ready_o SHALL be high only in IDLE.
REQ-005 IDLE: on req_valid_i & req_ready_o, the controller SHALL latch addr, we and data, then go to LOOKUP.
REQ-006 LOOKUP: way_index_o SHALL equal the latched index, and hit = valid[w] & tag match; more than one hitting way SHALL be treated as a design error (covered by an assertion).
REQ-007 Read hit: resp_data_o SHALL be the hit way's data from way_rdata_i, and resp_valid_o SHALL pulse in the cycle after LOOKUP (accept edge + 2 cycles).
REQ-008 Read miss: MEM_REQ SHALL hold mem_req_valid_o=1, mem_we_o=0 and mem_addr_o=latched addr until mem_req_ready_i; then MEM_WAIT until mem_resp_valid_i.
REQ-009 REFILL (one cycle): the victim way SHALL be written (way_we_o one-hot, way_wdata_o = memory data), with tag set and valid set; then RESP returns the memory data with resp_hit_o=0.
REQ-010 Victim selection SHALL be the lowest-index invalid way, otherwise the PLRU victim.
REQ-011 PLRU victim SHALL be chosen as follows: b0=0 selects ways 0/1 via b1 (0 gives way 0); b0=1 selects ways 2/3 via b2 (0 gives way 2).
REQ-012 PLRU update on a hit or refill of way w:
  w=0: b0=1, b1=1
  w=1: b0=1, b1=0
  w=2: b0=0, b2=1
  w=3: b0=0, b2=0
  Bits of other sets SHALL be unchanged.
REQ-013 Writes SHALL be write-through with no write-allocate.
  Write hit: in LOOKUP, way_we_o SHALL write the hit way and PLRU SHALL update.
  All writes: MEM_REQ with mem_we_o=1, then MEM_WAIT for the acknowledge, then RESP with resp_hit_o = hit.
REQ-014 mem_resp_valid_i SHALL be ignored outside MEM_WAIT; a response in the same cycle as acceptance SHALL wait for the next cycle.
REQ-015 way_we_o SHALL be 0 except in REFILL and in a write-hit LOOKUP.
REQ-016 Each LOOKUP SHALL increment exactly one of hit_cnt_o or miss_cnt_o; both SHALL saturate at 0xFFFF.
REQ-017 RESP SHALL last one cycle and then return to IDLE; back-to-back requests SHALL be accepted from IDLE without a bubble beyond RESP.

Reset
REQ-018 While rst_i is sampled high, the next state SHALL be IDLE, and all valid bits, PLRU bits and counters SHALL clear.
REQ-019 During the reset cycle all outputs SHALL be 0, including req_ready_o; req_ready_o SHALL rise on the first cycle after rst_i falls.
REQ-020 Reset mid-operation SHALL abort the transaction: mem_req_valid_o drops, no refill, no response.

Verification
REQ-021 Cold read: reset, read addr 0x13 (mem returns 0xDEAD_BEEF) -> miss, mem_addr_o=0x13, way_we_o=4'b0001, index 3, resp_data_o=0xDEADBEEF, resp_hit_o=0, miss_cnt_o=1.
REQ-022 Read hit latency: reread 0x13 -> resp_valid_o exactly 2 cycles after accept, data 0xDEADBEEF, resp_hit_o=1, no mem request.
REQ-023 PLRU eviction: read 0x03, 0x0B, 0x13, 0x1B (set 3 full), read 0x03, then read 0x23 -> the victim SHALL be way 2 (address 0x13); a following read of 0x13 misses.
REQ-024 Write-through: write 0x0B=0x1234 on a hit -> way 1 written and mem_we_o=1; write to uncached 0x40 -> no way_we_o, memory written, resp_hit_o=0.
REQ-025 Memory stalls: hold mem_req_ready_i low 5 cycles and give the response 7 cycles later -> mem_req_valid_o stable with a constant address, exactly one refill.
REQ-026 Reset in MEM_WAIT -> no response; after reset a read of the same address misses and the counters read 0/1.

Source files
------------

// File: rtl/four_way_cache_ctrl.sv
// Four-way set-associative write-through cache controller with tree-PLRU replacement.
// Holds tags, valid bits and PLRU state; the data arrays are external and read combinationally.
module four_way_cache_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SETS   = 8,
  parameter int unsigned NUM_WAYS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_we_i,
  input  logic [ADDR_WIDTH-1:0]          req_addr_i,
  input  logic [DATA_WIDTH-1:0]          req_data_i,
  output logic                           resp_valid_o,
  output logic [DATA_WIDTH-1:0]          resp_data_o,
  output logic                           resp_hit_o,
  output logic [$clog2(NUM_SETS)-1:0]    way_index_o,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] way_rdata_i,
  output logic [NUM_WAYS-1:0]            way_we_o,
  output logic [DATA_WIDTH-1:0]          way_wdata_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic                           mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]          mem_resp_data_i,
  output logic [15:0]                    hit_cnt_o,
  output logic [15:0]                    miss_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;
  localparam int unsigned WAY_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_REFILL,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tag_d   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
  logic [2:0]            plru_q  [NUM_SETS];
  logic [2:0]            plru_d  [NUM_SETS];
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [NUM_WAYS-1:0]   hit_vec;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim_way;

  // Tree bits after touching a way: b0 points away from the touched half, b1/b2 inside it.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [WAY_W-1:0] way);
    logic [2:0] nb;
    nb = bits;
    case (way)
      2'd0:    begin nb[0] = 1'b1; nb[1] = 1'b1; end
      2'd1:    begin nb[0] = 1'b1; nb[1] = 1'b0; end
      2'd2:    begin nb[0] = 1'b0; nb[2] = 1'b1; end
      default: begin nb[0] = 1'b0; nb[2] = 1'b0; end
    endcase
    return nb;
  endfunction

  // Tag compare and victim choice for the latched address.
  always_comb begin
    idx     = addr_q[IDX_W-1:0];
    tag     = addr_q[ADDR_WIDTH-1:IDX_W];
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = hit_way | WAY_W'(w);
    end
    hit_any = |hit_vec;
    if (!valid_q[idx][0])      victim_way = 2'd0;
    else if (!valid_q[idx][1]) victim_way = 2'd1;
    else if (!valid_q[idx][2]) victim_way = 2'd2;
    else if (!valid_q[idx][3]) victim_way = 2'd3;
    else if (!plru_q[idx][0])  victim_way = plru_q[idx][1] ? 2'd1 : 2'd0;
    else                       victim_way = plru_q[idx][2] ? 2'd3 : 2'd2;
  end

  // Next-state and array/counter updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    hit_d      = hit_q;
    rdata_d    = rdata_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    plru_d     = plru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          wdata_d = req_data_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d   = hit_any;
        rdata_d = '0;
        if (hit_any) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          plru_d[idx] = plru_touch(plru_q[idx], hit_way);
        end else if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
        if (!we_q && hit_any) begin
          rdata_d = way_rdata_i[32'(hit_way) * DATA_WIDTH +: DATA_WIDTH];
          state_d = S_RESP;
        end else begin
          state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready_i) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid_i) begin
          if (we_q) begin
            state_d = S_RESP;
          end else begin
            rdata_d = mem_resp_data_i;
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        tag_d[idx][victim_way]   = tag;
        valid_d[idx][victim_way] = 1'b1;
        plru_d[idx]              = plru_touch(plru_q[idx], victim_way);
        state_d                  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port decode from state; everything is forced low while reset is asserted.
  always_comb begin
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_data_o     = '0;
    resp_hit_o      = 1'b0;
    way_index_o     = '0;
    way_we_o        = '0;
    way_wdata_o     = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    hit_cnt_o       = '0;
    miss_cnt_o      = '0;
    if (!rst_i) begin
      way_index_o = idx;
      hit_cnt_o   = hit_cnt_q;
      miss_cnt_o  = miss_cnt_q;
      unique case (state_q)
        S_IDLE: req_ready_o = 1'b1;
        S_LOOKUP: begin
          if (we_q && hit_any) begin
            way_we_o    = NUM_WAYS'(1) << hit_way;
            way_wdata_o = wdata_q;
          end
        end
        S_MEM_REQ: begin
          mem_req_valid_o = 1'b1;
          mem_we_o        = we_q;
          mem_addr_o      = addr_q;
          mem_wdata_o     = we_q ? wdata_q : '0;
        end
        S_REFILL: begin
          way_we_o    = NUM_WAYS'(1) << victim_way;
          way_wdata_o = rdata_q;
        end
        S_RESP: begin
          resp_valid_o = 1'b1;
          resp_data_o  = rdata_q;
          resp_hit_o   = hit_q;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      rdata_q    <= '0;
      valid_q    <= '{default: '0};
      plru_q     <= '{default: '0};
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      hit_q      <= hit_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      plru_q     <= plru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tags are qualified by valid bits, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) tag_q <= tag_d;
  end

  a_single_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == S_LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_four_way_cache_ctrl.sv
// Bench for four_way_cache_ctrl: directed vector table, stall/reset sequences and random
// traffic checked against a set/way/PLRU reference model and an external data-array model.
module tb_four_way_cache_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NS = 8;
  localparam int unsigned NW = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  logic           req_we_i = 1'b0;
  logic [AW-1:0]  req_addr_i = '0;
  logic [DW-1:0]  req_data_i = '0;
  logic           resp_valid_o;
  logic [DW-1:0]  resp_data_o;
  logic           resp_hit_o;
  logic [2:0]     way_index_o;
  logic [NW*DW-1:0] way_rdata_i;
  logic [NW-1:0]  way_we_o;
  logic [DW-1:0]  way_wdata_o;
  logic           mem_req_valid_o;
  logic           mem_req_ready_i = 1'b0;
  logic           mem_we_o;
  logic [AW-1:0]  mem_addr_o;
  logic [DW-1:0]  mem_wdata_o;
  logic           mem_resp_valid_i = 1'b0;
  logic [DW-1:0]  mem_resp_data_i = '0;
  logic [15:0]    hit_cnt_o;
  logic [15:0]    miss_cnt_o;

  always #5 clk_i = ~clk_i;

  four_way_cache_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_hit_o(resp_hit_o),
    .way_index_o(way_index_o), .way_rdata_i(way_rdata_i), .way_we_o(way_we_o),
    .way_wdata_o(way_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  // External way data arrays
  logic [DW-1:0] ext_data [NW][NS];
  always @(posedge clk_i)
    for (int w = 0; w < NW; w++)
      if (way_we_o[w]) ext_data[w][way_index_o] <= way_wdata_o;
  always_comb
    for (int w = 0; w < NW; w++) way_rdata_i[w*DW +: DW] = ext_data[w][way_index_o];

  // Backing memory (responder side) and the model's expected memory
  logic [31:0] mem_act [logic [31:0]];
  logic [31:0] mem_exp [logic [31:0]];

  function automatic logic [31:0] rd_act(input logic [31:0] a);
    return mem_act.exists(a) ? mem_act[a] : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction
  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return mem_exp.exists(a) ? mem_exp[a] : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-set ways with tag/valid/data and the 3-bit tree
  logic        m_v    [NS][NW];
  logic [28:0] m_tag  [NS][NW];
  logic [31:0] m_d    [NS][NW];
  logic [2:0]  m_plru [NS];
  int          m_hits, m_miss;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_plru[s] = 3'b000;
      for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
    end
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    case (w)
      0:       begin m_plru[s][0] = 1'b1; m_plru[s][1] = 1'b1; end
      1:       begin m_plru[s][0] = 1'b1; m_plru[s][1] = 1'b0; end
      2:       begin m_plru[s][0] = 1'b0; m_plru[s][2] = 1'b1; end
      default: begin m_plru[s][0] = 1'b0; m_plru[s][2] = 1'b0; end
    endcase
  endtask

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                            output logic eh, output logic [31:0] ed, output logic [3:0] em);
    int s, hw, v;
    s  = int'(a[2:0]);
    hw = -1;
    for (int w = 0; w < NW; w++) if (m_v[s][w] && m_tag[s][w] == a[31:3]) hw = w;
    eh = (hw >= 0);
    em = 4'b0000;
    ed = 32'h0;
    if (eh) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
    else    m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
    if (we) begin
      mem_exp[a] = d;
      if (eh) begin
        m_d[s][hw] = d;
        model_touch(s, hw);
        em = 4'b0001 << hw;
      end
    end else if (eh) begin
      ed = m_d[s][hw];
      model_touch(s, hw);
    end else begin
      v = -1;
      for (int w = NW - 1; w >= 0; w--) if (!m_v[s][w]) v = w;
      if (v < 0) v = m_plru[s][0] ? (m_plru[s][2] ? 3 : 2) : (m_plru[s][1] ? 1 : 0);
      ed = rd_exp(a);
      m_v[s][v]   = 1'b1;
      m_tag[s][v] = a[31:3];
      m_d[s][v]   = ed;
      model_touch(s, v);
      em = 4'b0001 << v;
    end
  endtask

  // Observations of one transaction
  logic        o_seen, o_hit;
  logic [31:0] o_data, o_we_data, o_mem_wdata;
  logic [3:0]  o_we_mask;
  logic [15:0] o_hc, o_mc;
  int          o_lat, o_we_cnt, o_hs, o_mreq_cyc, o_bad;

  // Drive one request and act as memory; all sampling and driving on the falling edge.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int rdy_lat, input int rsp_lat, input logic spur);
    int  wait_cnt;
    logic hs_done, rsp_sent;
    o_seen = 0; o_hit = 0; o_data = 0; o_we_data = 0; o_mem_wdata = 0; o_we_mask = 0;
    o_hc = 0; o_mc = 0; o_lat = 0; o_we_cnt = 0; o_hs = 0; o_mreq_cyc = 0; o_bad = 0;
    hs_done = 0; rsp_sent = 0; wait_cnt = 0;
    @(negedge clk_i);
    for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_data_i = d;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      if (way_we_o != 0) begin
        o_we_cnt++; o_we_mask |= way_we_o; o_we_data = way_wdata_o;
      end
      if (resp_valid_o) begin
        o_seen = 1; o_hit = resp_hit_o; o_data = resp_data_o; o_lat = cyc;
        o_hc = hit_cnt_o; o_mc = miss_cnt_o;
        break;
      end
      if (mem_req_valid_o) begin
        o_mreq_cyc++;
        if (mem_addr_o !== a || mem_we_o !== we) o_bad++;
        if (o_mreq_cyc > rdy_lat) begin
          mem_req_ready_i = 1'b1; o_hs++; hs_done = 1; wait_cnt = 0;
          if (we) begin mem_act[a] = mem_wdata_o; o_mem_wdata = mem_wdata_o; end
          if (spur) begin mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hBAD0_BAD0; end
        end
      end else if (hs_done && !rsp_sent) begin
        wait_cnt++;
        if (wait_cnt > rsp_lat) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i  = we ? 32'h0 : rd_act(a);
          rsp_sent = 1;
        end
      end
      @(negedge clk_i);
    end
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
  endtask

  task automatic check_txn(input string nm, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input int rdy, input int rsp, input logic spur);
    logic eh;
    logic [31:0] ed;
    logic [3:0] em;
    model_step(we, a, d, eh, ed, em);
    run_txn(we, a, d, rdy, rsp, spur);
    check({nm, " resp seen"}, 32'(o_seen), 32'd1);
    check({nm, " hit"}, 32'(o_hit), 32'(eh));
    check({nm, " data"}, o_data, ed);
    check({nm, " way_we"}, 32'(o_we_mask), 32'(em));
    check({nm, " way_we count"}, o_we_cnt, (em != 0) ? 1 : 0);
    check({nm, " mem handshakes"}, o_hs, (we || !eh) ? 1 : 0);
    check({nm, " mem addr/we"}, o_bad, 0);
    check({nm, " hit_cnt"}, 32'(o_hc), m_hits);
    check({nm, " miss_cnt"}, 32'(o_mc), m_miss);
    if (em != 0) check({nm, " way_wdata"}, o_we_data, we ? d : ed);
    if (we) check({nm, " mem_wdata"}, o_mem_wdata, d);
    if (!we && eh) check({nm, " hit latency"}, o_lat, 2);
  endtask

  task automatic do_reset(input string nm);
    rst_i = 1'b1; req_valid_i = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check({nm, " outputs in reset"},
          32'({req_ready_o, resp_valid_o, mem_req_valid_o, mem_we_o, way_we_o, resp_hit_o}), 32'd0);
    check({nm, " counters in reset"}, {hit_cnt_o, miss_cnt_o}, 32'd0);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    check({nm, " ready after reset"}, 32'(req_ready_o), 32'd1);
  endtask

  typedef struct {
    logic        rst_before;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs [13];
  int   quiet_bad;

  initial begin : main
    vecs[0]  = '{1'b1, 1'b0, 32'h13, 32'h0,    1'b0, 32'hDEAD_BEEF, 4'b0001};
    vecs[1]  = '{1'b0, 1'b0, 32'h13, 32'h0,    1'b1, 32'hDEAD_BEEF, 4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h03, 32'h0,    1'b0, 32'hC0DE_0003, 4'b0001};
    vecs[3]  = '{1'b0, 1'b0, 32'h0B, 32'h0,    1'b0, 32'hC0DE_000B, 4'b0010};
    vecs[4]  = '{1'b0, 1'b0, 32'h13, 32'h0,    1'b0, 32'hDEAD_BEEF, 4'b0100};
    vecs[5]  = '{1'b0, 1'b0, 32'h1B, 32'h0,    1'b0, 32'hC0DE_001B, 4'b1000};
    vecs[6]  = '{1'b0, 1'b0, 32'h03, 32'h0,    1'b1, 32'hC0DE_0003, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 32'h23, 32'h0,    1'b0, 32'hC0DE_0023, 4'b0100};
    vecs[8]  = '{1'b0, 1'b1, 32'h0B, 32'h1234, 1'b1, 32'h0,         4'b0010};
    vecs[9]  = '{1'b0, 1'b0, 32'h13, 32'h0,    1'b0, 32'hDEAD_BEEF, 4'b1000};
    vecs[10] = '{1'b0, 1'b0, 32'h0B, 32'h0,    1'b1, 32'h0000_1234, 4'b0000};
    vecs[11] = '{1'b0, 1'b1, 32'h40, 32'h5555, 1'b0, 32'h0,         4'b0000};
    vecs[12] = '{1'b0, 1'b0, 32'h40, 32'h0,    1'b0, 32'h0000_5555, 4'b0001};

    mem_act[32'h13] = 32'hDEAD_BEEF;
    mem_exp[32'h13] = 32'hDEAD_BEEF;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst_before) do_reset($sformatf("vec%0d", i));
      check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, 0, 0, 1'b0);
      check($sformatf("vec%0d table hit", i), 32'(o_hit), 32'(vecs[i].exp_hit));
      check($sformatf("vec%0d table data", i), o_data, vecs[i].exp_data);
      check($sformatf("vec%0d table way_we", i), 32'(o_we_mask), 32'(vecs[i].exp_mask));
    end

    // Memory stalls plus a response pulse coincident with acceptance that must be ignored
    check_txn("stall", 1'b0, 32'h2F, 32'h0, 5, 7, 1'b1);
    check("stall mem_req_valid cycles", o_mreq_cyc, 32'd6);

    // Reset while waiting for memory
    do_reset("mid");
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h55;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = '0;
    for (int i = 0; i < 10 && !mem_req_valid_o; i++) @(negedge clk_i);
    check("mid mem_req_valid", 32'(mem_req_valid_o), 32'd1);
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    @(negedge clk_i);
    check("mid in mem_wait", 32'({mem_req_valid_o, resp_valid_o}), 32'd0);
    rst_i = 1'b1;
    #1;
    check("mid outputs at reset", 32'({req_ready_o, mem_req_valid_o, resp_valid_o, way_we_o}), 32'd0);
    do_reset("mid2");
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h7777_7777;
    quiet_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      mem_resp_valid_i = 1'b0;
      if (resp_valid_o || way_we_o != 0 || mem_req_valid_o) quiet_bad++;
    end
    check("mid no response after abort", quiet_bad, 32'd0);
    check_txn("post-abort", 1'b0, 32'h55, 32'h0, 1, 1, 1'b0);
    check("post-abort counters", {o_hc, o_mc}, {16'd0, 16'd1});

    // Random traffic against the model
    for (int n = 0; n < 150; n++) begin
      logic        we;
      logic [31:0] a;
      we = ($urandom_range(0, 9) < 3);
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'h0100_0000;
      check_txn("rnd", we, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
